// File: rtl/stat_pkg.sv
// Shared types and default widths for the windowed statistics counter.
package stat_pkg;

    localparam int unsigned DefCountW = 32;
    localparam int unsigned DefIncW   = 4;
    localparam int unsigned DefWinW   = 16;

    typedef logic [DefCountW-1:0] stat_count_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        CLEAR
    } stat_state_e;

endpackage

// File: rtl/stat_window_counter_if.sv
// Event-tap / statistics bundle. master = the counter, slave = the side driving taps
// and consuming snapshots.
interface stat_window_counter_if
    import stat_pkg::*;
#(
    parameter int unsigned COUNT_W = DefCountW,
    parameter int unsigned INC_W   = DefIncW,
    parameter int unsigned WIN_W   = DefWinW
);
    logic               enable;
    logic               event_valid;
    logic [INC_W-1:0]   event_inc;
    logic [WIN_W-1:0]   window_len;
    logic               clear_req;
    logic               clear_ack;
    logic               stat_valid;
    logic               stat_reset;
    logic [COUNT_W-1:0] stat_count;
    logic               stat_overflow;

    modport master (
        input  enable, event_valid, event_inc, window_len, clear_req,
        output clear_ack, stat_valid, stat_reset, stat_count, stat_overflow
    );

    modport slave (
        output enable, event_valid, event_inc, window_len, clear_req,
        input  clear_ack, stat_valid, stat_reset, stat_count, stat_overflow
    );

endinterface

// File: rtl/stat_window_timer.sv
// Window down-counter: load max(len,1)-1, decrement while running, flag terminal at zero.
module stat_window_timer #(
    parameter int unsigned WIN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [WIN_W-1:0] len_i,
    output logic             terminal_o
);

    logic [WIN_W-1:0] timer_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_q <= '0;
        end else if (load_i) begin
            timer_q <= (len_i == '0) ? '0 : len_i - WIN_W'(1);
        end else if (run_i && (timer_q != '0)) begin
            timer_q <= timer_q - WIN_W'(1);
        end
    end

    assign terminal_o = (timer_q == '0);

endmodule

// File: rtl/stat_window_counter.sv
// Windowed event accumulator emitting one-cycle snapshot and clear strobes.
// Build option: STAT_WINDOW_SATURATE_EN makes the accumulator saturate instead of wrap.
module stat_window_counter
    import stat_pkg::*;
#(
    parameter int unsigned COUNT_W = DefCountW,
    parameter int unsigned INC_W   = DefIncW,
    parameter int unsigned WIN_W   = DefWinW
) (
    input  logic                   clk,
    input  logic                   reset,
    stat_window_counter_if.master  stat_io
);

    stat_state_e        state_q;
    logic               clr_req_q;
    logic [COUNT_W-1:0] acc_q;
    logic               ovf_q;
    logic               stat_valid_q;
    logic               stat_reset_q;
    logic [COUNT_W-1:0] stat_count_q;
    logic               stat_overflow_q;

    logic               clr_edge;
    logic               active;
    logic               terminal;
    logic               tmr_load;
    logic [COUNT_W-1:0] inc_ext;
    logic [COUNT_W:0]   sum;
    logic               carry;
    logic [COUNT_W-1:0] acc_add;

    always_comb begin
        clr_edge = stat_io.clear_req & ~clr_req_q;
        // PAUSE with enable high resumes the window in the same cycle.
        active   = stat_io.enable & ((state_q == RUN) | (state_q == PAUSE));
        inc_ext  = stat_io.event_valid ? COUNT_W'(stat_io.event_inc) : '0;
        sum      = {1'b0, acc_q} + {1'b0, inc_ext};
        carry    = sum[COUNT_W];
`ifdef STAT_WINDOW_SATURATE_EN
        acc_add  = carry ? '1 : sum[COUNT_W-1:0];
`else
        acc_add  = sum[COUNT_W-1:0];
`endif
        tmr_load = ~clr_edge & ((state_q == CLEAR) |
                                ((state_q == IDLE) & stat_io.enable) |
                                (active & terminal));
    end

    stat_window_timer #(
        .WIN_W (WIN_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .run_i      (active & ~clr_edge),
        .len_i      (stat_io.window_len),
        .terminal_o (terminal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            clr_req_q       <= 1'b0;
            acc_q           <= '0;
            ovf_q           <= 1'b0;
            stat_valid_q    <= 1'b0;
            stat_reset_q    <= 1'b0;
            stat_count_q    <= '0;
            stat_overflow_q <= 1'b0;
        end else begin
            clr_req_q    <= stat_io.clear_req;
            stat_valid_q <= 1'b0;
            stat_reset_q <= 1'b0;
            if (clr_edge) begin
                // A clear beats everything, including a terminal cycle's snapshot.
                state_q         <= CLEAR;
                acc_q           <= '0;
                ovf_q           <= 1'b0;
                stat_reset_q    <= 1'b1;
                stat_count_q    <= '0;
                stat_overflow_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (stat_io.enable) begin
                            state_q <= RUN;
                        end
                    end
                    RUN, PAUSE: begin
                        if (active) begin
                            state_q <= RUN;
                            if (terminal) begin
                                stat_valid_q    <= 1'b1;
                                stat_count_q    <= acc_add;
                                stat_overflow_q <= ovf_q | carry;
                                acc_q           <= '0;
                                ovf_q           <= 1'b0;
                            end else begin
                                acc_q <= acc_add;
                                ovf_q <= ovf_q | carry;
                            end
                        end else begin
                            state_q <= PAUSE;
                        end
                    end
                    CLEAR: begin
                        state_q <= stat_io.enable ? RUN : IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign stat_io.stat_valid    = stat_valid_q;
    assign stat_io.stat_reset    = stat_reset_q;
    assign stat_io.clear_ack     = stat_reset_q;
    assign stat_io.stat_count    = stat_count_q;
    assign stat_io.stat_overflow = stat_overflow_q;

endmodule

// File: doc/stat_window_counter.md
Name: stat_window_counter

Overview:
- Upstream producer for the statistics consumer. It accumulates raw event increments over a programmable window of cycles.
- At each window end it emits a one-cycle stat_valid strobe with a snapshot count.
- On a software clear it emits a one-cycle stat_reset strobe.
- Sits between datapath event taps and the statistics/memory-mapped stage.

Parameters:
- COUNT_W, 32: accumulator and snapshot width.
- INC_W, 4: width of the per-cycle event increment.
- WIN_W, 16: width of the window length.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = run; 0 = pause (timer and accumulator hold).
- event_valid  input  1  event_inc is valid this cycle.
- event_inc  input  INC_W  increment added when event_valid=1.
- window_len  input  WIN_W  window length in cycles; sampled at each window start; 0 is treated as 1.
- clear_req  input  1  clear request; rising-edge detected.
- clear_ack  output  1  one-cycle acknowledge of a clear.
- stat_valid  output  1  one-cycle strobe; snapshot outputs valid this cycle.
- stat_reset  output  1  one-cycle strobe; the consumer must clear its state.
- stat_count  output  COUNT_W  snapshot of the window total.
- stat_overflow  output  1  accumulator overflowed during the snapshot's window.

Behaviour:
- Clocking/reset: one clock (clk); reset is asynchronous, active-high.
- Reset values: all outputs 0; state=IDLE; acc=0; timer=0; clear_req edge register=0.
- States:
  - IDLE: enable=0 since reset or since the last clear. enable=1 -> RUN and load timer=max(window_len,1)-1.
  - RUN: each cycle, acc += event_inc if event_valid.
    - timer!=0: decrement timer.
    - timer==0 (terminal): next cycle stat_valid=1, stat_count = acc including the terminal-cycle increment, stat_overflow = window overflow flag. acc restarts from 0 (no lost cycle), overflow flag clears, timer reloads from the current window_len.
    - enable=0 in RUN: PAUSE.
  - PAUSE: acc, timer and events frozen; events are dropped. enable=1 -> RUN, resuming the same window.
  - CLEAR: entered from any state on a clear_req rising edge. Lasts exactly one cycle:
    - acc=0, overflow flag=0, timer reloaded.
    - stat_reset=1 and clear_ack=1 on the following cycle.
    - Events in the CLEAR cycle are dropped.
    - Exit to RUN if enable=1, else IDLE.
- Latency: event to inclusion is 0 cycles (same-cycle add); terminal cycle to stat_valid is 1 cycle.
- Simultaneous events:
  - Clear edge on a terminal cycle: clear wins; no stat_valid is produced for that window.
  - Clear edge during PAUSE: handled as above.
  - stat_valid and stat_reset are never asserted in the same cycle.
- Accumulator arithmetic: zero-extend event_inc to COUNT_W+1 and add. A carry out of COUNT_W sets the window overflow flag; behaviour on carry is set by the optional feature.
- stat_count/stat_overflow: hold their value between strobes; cleared to 0 on a clear.
- window_len changes mid-window take effect at the next window start only.
- Reset asserted mid-window: everything returns to reset values immediately; no strobe is generated.

Optional Feature:
- Macro: STAT_WINDOW_SATURATE_EN.
  - Defined: acc saturates at all-ones on carry; overflow flag set.
  - Undefined: acc wraps modulo 2^COUNT_W; overflow flag set (sticky for the window).

Decomposition:
- Package stat_pkg:
  - stat_count_t (logic [COUNT_W-1:0]).
  - stat_state_e enum {IDLE, RUN, PAUSE, CLEAR}.
  - Default width localparams.
- One natural sub-module, stat_window_timer: load/decrement/terminal flag with a pause input, instantiated once.

Test Plan:
- window_len=4, enable=1, event_valid=1, event_inc=1 every cycle -> stat_valid pulses every 4 cycles, stat_count=4, stat_overflow=0; the first pulse is 5 cycles after enable rises.
- COUNT_W=8, window_len=100, event_inc=3 every cycle:
  - SATURATE_EN defined -> stat_count=255, overflow=1.
  - Undefined -> stat_count=300 mod 256=44, overflow=1.
- window_len=8; clear_req edge on the terminal cycle -> next cycle stat_reset=1 and clear_ack=1, stat_valid=0, stat_count=0; the next window yields a full 8-cycle count.
- window_len=6, inc=2; enable=0 for 3 cycles mid-window with event_valid=1 -> paused events dropped; stat_count=12 after 6 active cycles.
- Assert reset at window cycle 3 of 5 -> all outputs 0 immediately; after release with enable=1, the first stat_valid comes 6 cycles later with count 5 (inc=1).
- window_len=0, inc=1 -> stat_valid every cycle, stat_count=1.
